// File: rtl/ex_div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU in the EX stage.
// Quotient goes to result_lo and remainder to result_hi; stall is held while the divide is in flight.
module ex_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic        flush,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        stall,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic [31:0] dvd_abs, dvs_abs;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        qbit;
  logic [31:0] rem_step, quo_step;

  // Magnitudes wrap modulo 2^32, so 0x80000000 stays 0x80000000 as an unsigned value.
  assign dvd_abs = (is_signed && operand_1[31]) ? (32'd0 - operand_1) : operand_1;
  assign dvs_abs = (is_signed && operand_2[31]) ? (32'd0 - operand_2) : operand_2;

  // The dividend register shifts left each step; quotient bits fill in from the LSB.
  assign shifted  = {rem_q, dvd_q[31]};
  assign diff     = {1'b0, shifted} - {2'b00, dvs_q};
  assign qbit     = ~diff[33];
  assign rem_step = qbit ? diff[31:0] : shifted[31:0];
  assign quo_step = {dvd_q[30:0], qbit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          negq_d = is_signed && (operand_1[31] ^ operand_2[31]);
          negr_d = is_signed && operand_1[31];
          dvd_d  = dvd_abs;
          dvs_d  = dvs_abs;
          rem_d  = 32'd0;
          cnt_d  = 5'd0;
          if (operand_2 == 32'd0) begin
            lo_d    = 32'hFFFF_FFFF;
            hi_d    = operand_1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          lo_d    = negq_q ? (32'd0 - quo_step) : quo_step;
          hi_d    = negr_q ? (32'd0 - rem_step) : rem_step;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush discards the in-flight divide without touching the visible results.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      lo_d    = lo_q;
      hi_d    = hi_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign stall     = !rst && !flush && (((state_q == IDLE) && start) || (state_q == RUN));
  assign done      = (state_q == DONE);
  assign result_lo = lo_q;
  assign result_hi = hi_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit: results, stall/done timing, flush and reset behaviour.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        flush;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        stall;
  logic        done;
  logic [31:0] rlo;
  logic [31:0] rhi;

  int errors = 0;
  int checks = 0;
  int st;
  int di;
  int n_done;
  int n_st;

  ex_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .flush     (flush),
    .operand_1 (op1),
    .operand_2 (op2),
    .stall     (stall),
    .done      (done),
    .result_lo (rlo),
    .result_hi (rhi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one divide, counts stall cycles and the cycle index of done (start cycle = 0).
  // Operands are scrambled after acceptance to show they are not re-sampled.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit hold, output int stall_cnt, output int done_idx);
    stall_cnt = 0;
    done_idx  = -1;
    @(negedge clk);
    start = 1'b1; is_signed = s; op1 = a; op2 = b;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (stall) stall_cnt++;
      if (done) begin
        done_idx = i;
        break;
      end
      if (i == 2) begin
        op1 = ~a; op2 = b + 32'd5; is_signed = ~s;
      end
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic count_idle(input int cycles, output int dn, output int sn);
    dn = 0;
    sn = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (done) dn++;
      if (stall) sn++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; flush = 1'b0; is_signed = 1'b0; op1 = 32'd100; op2 = 32'd7;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_lo", rlo, 32'd0);
    chk("rst_hi", rhi, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);

    run_div(32'd100, 32'd7, 1'b0, 1'b0, st, di);
    chk("divu100_stall_cycles", st, 32'd33);
    chk("divu100_done_cycle", di, 32'd33);
    chk("divu100_lo", rlo, 32'd14);
    chk("divu100_hi", rhi, 32'd2);
    @(negedge clk);
    #1;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("lo_held", rlo, 32'd14);

    // Flush ten cycles into a divide
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op1 = 32'd50; op2 = 32'd3;
    #1;
    chk("flush_start_stall", {31'd0, stall}, 32'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    #1;
    chk("flush_stall_low", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    count_idle(40, n_done, n_st);
    chk("flush_no_done", n_done, 32'd0);
    chk("flush_no_stall", n_st, 32'd0);
    chk("flush_lo_kept", rlo, 32'd14);
    chk("flush_hi_kept", rhi, 32'd2);

    // Flush and start together: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op1 = 32'd50; op2 = 32'd3;
    #1;
    chk("flush_start_same_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    count_idle(40, n_done, n_st);
    chk("flush_start_no_done", n_done, 32'd0);
    chk("flush_start_no_run", n_st, 32'd0);

    run_div(32'd50, 32'd3, 1'b0, 1'b0, st, di);
    chk("divu50_stall_cycles", st, 32'd33);
    chk("divu50_done_cycle", di, 32'd33);
    chk("divu50_lo", rlo, 32'd16);
    chk("divu50_hi", rhi, 32'd2);

    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, st, di);
    chk("div_m7_lo", rlo, 32'hFFFF_FFFD);
    chk("div_m7_hi", rhi, 32'hFFFF_FFFF);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, st, di);
    chk("divu_m7_lo", rlo, 32'h7FFF_FFFC);
    chk("divu_m7_hi", rhi, 32'd1);

    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, st, di);
    chk("div_ovf_lo", rlo, 32'h8000_0000);
    chk("div_ovf_hi", rhi, 32'd0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, st, di);
    chk("divu_max_lo", rlo, 32'hFFFF_FFFF);
    chk("divu_max_hi", rhi, 32'd0);

    run_div(32'd1234, 32'd0, 1'b0, 1'b0, st, di);
    chk("div0u_stall_cycles", st, 32'd1);
    chk("div0u_done_cycle", di, 32'd1);
    chk("div0u_lo", rlo, 32'hFFFF_FFFF);
    chk("div0u_hi", rhi, 32'd1234);
    run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, st, di);
    chk("div0s_lo", rlo, 32'hFFFF_FFFF);
    chk("div0s_hi", rhi, 32'hFFFF_FFF9);

    // start held across DONE: next accept only from IDLE
    run_div(32'd200, 32'd9, 1'b0, 1'b1, st, di);
    chk("hold_first_done_cycle", di, 32'd33);
    run_div(32'd200, 32'd9, 1'b0, 1'b0, st, di);
    chk("hold_second_stall_cycles", st, 32'd33);
    chk("hold_second_done_cycle", di, 32'd33);
    chk("hold_lo", rlo, 32'd22);
    chk("hold_hi", rhi, 32'd2);

    // Reset in RUN cycle 5
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op1 = 32'd1000; op2 = 32'd10;
    repeat (5) @(negedge clk);
    #1;
    chk("run5_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_lo", rlo, 32'd0);
    chk("midrst_hi", rhi, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    count_idle(40, n_done, n_st);
    chk("midrst_no_done", n_done, 32'd0);
    chk("midrst_no_stall", n_st, 32'd0);

    run_div(32'd1001, 32'd10, 1'b0, 1'b0, st, di);
    chk("after_rst_done_cycle", di, 32'd33);
    chk("after_rst_lo", rlo, 32'd100);
    chk("after_rst_hi", rhi, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
